// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared definitions for the pipeline front end.
//                Holds the reset vector, the word size, the fetch->decode
//                bus type, the next-PC source selector, and a sequential-PC
//                helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int          XLEN             = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
    localparam logic [31:0] INST_NOP         = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;

    // Fetch -> decode payload. Decode unpacks the same struct.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fs_ds_bus_t;

    // Next-PC source. The encoding is listed in priority order, highest last.
    typedef enum logic [1:0] {
        NPC_SEQ    = 2'd0,
        NPC_BRANCH = 2'd1,
        NPC_FLUSH  = 2'd2
    } npc_sel_e;

    // Sequential successor. Wraps modulo 2^32 by construction.
    function automatic logic [XLEN-1:0] seq_pc(input logic [XLEN-1:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage_if
//  Description : Bundle of the fetch-stage handshake and bus signals.
//                It carries the redirect inputs, the decode handshake, the
//                instruction SRAM port and the fetch->decode payload.
//                The master modport is the fetch-stage view. The slave
//                modport is the view of the surrounding pipeline and memory.
//  Ports       : ds_allowin, br_taken/br_target, flush/flush_target,
//                inst_sram_{en,wen,addr,wdata,rdata},
//                fs_to_ds_valid, fs_pc, fs_inst
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_stage_if;
    import cpu_pkg::*;

    // redirect / handshake from later stages
    logic            ds_allowin;
    logic            br_taken;
    logic [XLEN-1:0] br_target;
    logic            flush;
    logic [XLEN-1:0] flush_target;

    // instruction SRAM
    logic            inst_sram_en;
    logic [3:0]      inst_sram_wen;
    logic [XLEN-1:0] inst_sram_addr;
    logic [XLEN-1:0] inst_sram_wdata;
    logic [XLEN-1:0] inst_sram_rdata;

    // fetch -> decode
    logic            fs_to_ds_valid;
    logic [XLEN-1:0] fs_pc;
    logic [XLEN-1:0] fs_inst;

    modport master (
        input  ds_allowin, br_taken, br_target, flush, flush_target,
        input  inst_sram_rdata,
        output inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
        output fs_to_ds_valid, fs_pc, fs_inst
    );

    modport slave (
        output ds_allowin, br_taken, br_target, flush, flush_target,
        output inst_sram_rdata,
        input  inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
        input  fs_to_ds_valid, fs_pc, fs_inst
    );

endinterface
`default_nettype wire

// File: rtl/fetch_skid_buf.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_skid_buf
//  Description : One-entry holding register for the fetched instruction.
//                The synchronous SRAM presents a word for a single cycle
//                only. If decode stalls, that word is captured on the first
//                stall cycle and replayed until the stall ends, so the SRAM
//                output may change freely afterwards.
//  Ports       : clk, resetn  - clock, async active-low reset
//                capture      - IF holds a valid instruction that decode refused
//                buf_release  - drop any held word (decode accepted, or flush)
//                rdata        - SRAM read data
//                inst         - held word if present, else live SRAM data
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_skid_buf
    import cpu_pkg::*;
(
    input  logic            clk,
    input  logic            resetn,
    input  logic            capture,
    input  logic            buf_release,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] inst
);

    logic            buf_valid_q, buf_valid_d;
    logic [XLEN-1:0] buf_inst_q,  buf_inst_d;

    // Release beats capture. A flush during a stall must not latch the
    // stale word it is discarding. Only the first stall cycle captures,
    // because later cycles may see scrambled SRAM data.
    always_comb begin
        buf_valid_d = buf_valid_q;
        buf_inst_d  = buf_inst_q;
        if (buf_release) begin
            buf_valid_d = 1'b0;
        end else if (capture && !buf_valid_q) begin
            buf_valid_d = 1'b1;
            buf_inst_d  = rdata;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            buf_valid_q <= 1'b0;
            buf_inst_q  <= INST_NOP;
        end else begin
            buf_valid_q <= buf_valid_d;
            buf_inst_q  <= buf_inst_d;
        end
    end

    assign inst = buf_valid_q ? buf_inst_q : rdata;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage
//  Description : Instruction-fetch stage of the five-stage pipeline.
//                It selects the next PC (flush > branch > sequential) and
//                drives the synchronous instruction SRAM with it. It keeps
//                the PC of the instruction currently in IF. It offers
//                {pc, inst} to decode through a valid/allowin handshake.
//                A skid buffer keeps the word stable across decode stalls.
//  Ports       : clk     - rising-edge clock
//                resetn  - asynchronous active-low reset
//                fs      - fetch_stage_if.master (redirects, decode
//                          handshake, instruction SRAM, fetch->decode bus)
//  Params      : RESET_PC - first address fetched after reset
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
)(
    input  logic          clk,
    input  logic          resetn,
    fetch_stage_if.master fs
);

    // The PC register resets one word below the vector. The sequential
    // successor is then the vector itself, so the first fetch needs no
    // special case.
    localparam logic [XLEN-1:0] RESET_PC_PRE = RESET_PC - PC_STEP;

    logic            fs_valid_q, fs_valid_d;
    logic [XLEN-1:0] fs_pc_q,    fs_pc_d;

    logic            fs_allowin;
    logic            fetch_req;
    npc_sel_e        npc_sel;
    logic [XLEN-1:0] nextpc;
    logic            skid_capture;
    logic            skid_release;
    logic [XLEN-1:0] skid_inst;
    fs_ds_bus_t      fs_ds_bus;

    // IF ready_go is always 1, so IF can take a new word whenever it is
    // empty or its current word leaves this cycle.
    assign fs_allowin = !fs_valid_q || fs.ds_allowin;

    // A branch only matters when the delay slot is actually leaving. If
    // fs_allowin is low, no request goes out and the selection is unused.
    // Decode keeps br_taken asserted until its stall ends.
    always_comb begin
        npc_sel = NPC_SEQ;
        if (fs.flush) begin
            npc_sel = NPC_FLUSH;
        end else if (fs.br_taken) begin
            npc_sel = NPC_BRANCH;
        end
    end

    // Targets pass through unaligned; address errors are raised downstream.
    always_comb begin
        nextpc = seq_pc(fs_pc_q);
        case (npc_sel)
            NPC_FLUSH:  nextpc = fs.flush_target;
            NPC_BRANCH: nextpc = fs.br_target;
            default:    nextpc = seq_pc(fs_pc_q);
        endcase
    end

    // A flush refetches even while decode is stalled. The word in IF is
    // thrown away, so nothing has to wait for it.
    assign fetch_req = resetn && (fs.flush || fs_allowin);

    always_comb begin
        fs_valid_d = fs_valid_q;
        fs_pc_d    = fs_pc_q;
        if (fetch_req) begin
            fs_valid_d = 1'b1;
            fs_pc_d    = nextpc;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fs_valid_q <= 1'b0;
            fs_pc_q    <= RESET_PC_PRE;
        end else begin
            fs_valid_q <= fs_valid_d;
            fs_pc_q    <= fs_pc_d;
        end
    end

    // The buffer captures whenever decode refuses a valid word. It keeps
    // only the first such word internally, and drops it when decode takes
    // the word or a flush discards it.
    assign skid_capture = fs_valid_q && !fs.ds_allowin;
    assign skid_release = fs.ds_allowin || fs.flush;

    fetch_skid_buf u_skid (
        .clk         (clk),
        .resetn      (resetn),
        .capture     (skid_capture),
        .buf_release (skid_release),
        .rdata       (fs.inst_sram_rdata),
        .inst        (skid_inst)
    );

    // An empty IF shows zeros, which keeps decode-side debug traces clean.
    assign fs_ds_bus.pc   = fs_valid_q ? fs_pc_q   : '0;
    assign fs_ds_bus.inst = fs_valid_q ? skid_inst : INST_NOP;

    assign fs.fs_to_ds_valid  = fs_valid_q && !fs.flush;
    assign fs.fs_pc           = fs_ds_bus.pc;
    assign fs.fs_inst         = fs_ds_bus.inst;

    assign fs.inst_sram_en    = fetch_req;
    assign fs.inst_sram_wen   = 4'b0000;
    assign fs.inst_sram_addr  = nextpc;
    assign fs.inst_sram_wdata = '0;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_stage
//  Description : Self-checking bench for fetch_stage.
//                The stimulus side keeps a program-order model: the PC held
//                in IF and whether IF is occupied. Each cycle it queues the
//                expected SRAM request and offer. Each time the model says an
//                instruction is handed over, it also queues the expected
//                {pc, inst}. A negedge monitor pops and compares.
//                The SRAM model returns the address as data. It scrambles its
//                output whenever no request is made.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;
    import cpu_pkg::*;

    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

    typedef struct {
        bit          en;
        logic [31:0] addr;
        bit          offer;
    } cyc_t;

    logic clk;
    logic resetn;

    fetch_stage_if bus ();

    fetch_stage #(.RESET_PC(RESET_PC)) dut (
        .clk    (clk),
        .resetn (resetn),
        .fs     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous SRAM: word = address. Output is garbage when idle.
    always @(posedge clk) begin
        if (bus.inst_sram_en) bus.inst_sram_rdata <= bus.inst_sram_addr;
        else                  bus.inst_sram_rdata <= $urandom;
    end

    int total = 0;
    int bad   = 0;

    cyc_t        cycq[$];
    logic [31:0] delq[$];

    // reference model state
    bit          m_valid;
    logic [31:0] m_cur;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: per-cycle request/offer, and each accepted hand-over.
    always @(negedge clk) begin
        if (resetn) begin
            if (cycq.size() == 0) begin
                total++; bad++;
                $display("FAIL cyc_underflow: no expected cycle entry at %0t", $time);
            end else begin
                cyc_t c;
                c = cycq.pop_front();
                chk("sram_en",    {31'd0, bus.inst_sram_en},   {31'd0, c.en});
                chk("sram_addr",  bus.inst_sram_addr,          c.addr);
                chk("offer",      {31'd0, bus.fs_to_ds_valid}, {31'd0, c.offer});
            end
            if (bus.fs_to_ds_valid && bus.ds_allowin) begin
                if (delq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_delivery: pc %h at %0t", bus.fs_pc, $time);
                end else begin
                    logic [31:0] p;
                    p = delq.pop_front();
                    chk("deliver_pc",   bus.fs_pc,   p);
                    chk("deliver_inst", bus.fs_inst, p);   // SRAM word == address
                end
            end
        end
    end

    // One pipeline cycle of stimulus, plus the model's view of it.
    task automatic drive(input bit al, input bit br, input logic [31:0] bt,
                         input bit fl, input logic [31:0] ft, input bit rel);
        cyc_t        c;
        logic [31:0] npc;
        @(posedge clk); #1;
        bus.ds_allowin   = al;
        bus.br_taken     = br;
        bus.br_target    = bt;
        bus.flush        = fl;
        bus.flush_target = ft;
        if (rel) resetn = 1'b1;

        // A new fetch happens on a flush, or when IF is empty or its word leaves.
        // The fetch goes to the redirect target, else the next sequential word.
        npc     = fl ? ft : (br ? bt : m_cur + 32'd4);
        c.en    = fl || !m_valid || al;
        c.addr  = npc;
        c.offer = m_valid && !fl;
        cycq.push_back(c);
        if (m_valid && !fl && al) delq.push_back(m_cur);
        if (c.en) begin
            m_valid = 1'b1;
            m_cur   = npc;
        end
    endtask

    task automatic go(input bit al);
        drive(al, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic do_reset();
        resetn           = 1'b0;
        bus.ds_allowin   = 1'b1;
        bus.br_taken     = 1'b0;
        bus.br_target    = 32'h0;
        bus.flush        = 1'b0;
        bus.flush_target = 32'h0;
        #1;
        chk("rst_en",    {31'd0, bus.inst_sram_en},   32'd0);
        chk("rst_addr",  bus.inst_sram_addr,          RESET_PC);
        chk("rst_valid", {31'd0, bus.fs_to_ds_valid}, 32'd0);
        chk("rst_pc",    bus.fs_pc,                   32'd0);
        chk("rst_inst",  bus.fs_inst,                 32'd0);
        chk("rst_wen",   {28'd0, bus.inst_sram_wen},  32'd0);
        m_valid = 1'b0;
        m_cur   = RESET_PC - 32'd4;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        resetn           = 1'b1;
        bus.ds_allowin   = 1'b1;
        bus.br_taken     = 1'b0;
        bus.br_target    = 32'h0;
        bus.flush        = 1'b0;
        bus.flush_target = 32'h0;
        #1;
        do_reset();

        // Straight-line fetch from the reset vector.
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        go(1'b1);
        go(1'b1);

        // Five-cycle stall with BFC00008 in IF.
        repeat (5) go(1'b0);
        go(1'b1);
        go(1'b1);

        // Taken branch with BFC00010 as the delay slot.
        drive(1'b1, 1'b1, 32'hBFC0_0100, 1'b0, 32'h0, 1'b0);

        // Branch held across a 3-cycle stall.
        repeat (3) drive(1'b0, 1'b1, 32'hBFC0_0200, 1'b0, 32'h0, 1'b0);
        drive(1'b1, 1'b1, 32'hBFC0_0200, 1'b0, 32'h0, 1'b0);

        // Flush while stalled with the buffer full.
        repeat (2) go(1'b0);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'hBFC0_0380, 1'b0);
        repeat (3) go(1'b1);

        // Reset in the middle of a stall.
        repeat (2) go(1'b0);
        @(negedge clk); #1;
        do_reset();

        // Flush in the first cycle after reset release.
        drive(1'b1, 1'b0, 32'h0, 1'b1, 32'hBFC0_0040, 1'b1);
        go(1'b1);

        // Randomized traffic with one reset along the way.
        for (int i = 0; i < 400; i++) begin
            bit          al, br, fl;
            logic [31:0] bt, ft;
            if (i == 200) begin
                @(negedge clk); #1;
                do_reset();
                drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
            end
            al = ($urandom_range(3) != 0);
            br = ($urandom_range(5) == 0);
            fl = ($urandom_range(15) == 0);
            bt = {16'hBFC0, 14'($urandom), 2'b00};
            ft = {16'hBFC0, 14'($urandom), 2'b00};
            drive(al, br, bt, fl, ft, 1'b0);
        end

        // Wrap of the sequential PC at the top of the address space.
        drive(1'b1, 1'b1, 32'hFFFF_FFF8, 1'b0, 32'h0, 1'b0);
        repeat (4) go(1'b1);

        @(negedge clk); #1;
        chk("cyc_leftover", cycq.size(), 32'd0);
        chk("del_leftover", delq.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the five-stage MIPS-style pipeline, sitting directly upstream of the decode stage. It generates the next PC, drives the synchronous instruction SRAM, holds the fetched instruction across decode stalls, and applies branch redirects after the delay slot and exception/flush redirects. It hands `{pc, inst}` to decode through a valid/allowin handshake.

## Interface
- `RESET_PC`, default `32'hBFC0_0000`: first instruction address fetched after reset.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `ds_allowin`  in  1  decode accepts a new instruction this cycle.
- `br_taken`  in  1  level from decode: taken branch or jump in decode; the instruction currently in IF is its delay slot.
- `br_target`  in  32  branch/jump target, valid while `br_taken`.
- `flush`  in  1  exception/eret redirect from a later stage; one-cycle pulse.
- `flush_target`  in  32  redirect PC, valid while `flush`.
- `inst_sram_en`  out  1  fetch request.
- `inst_sram_wen`  out  4  constant 0.
- `inst_sram_addr`  out  32  fetch address (`nextpc`).
- `inst_sram_wdata`  out  32  constant 0.
- `inst_sram_rdata`  in  32  read data; valid one cycle after an accepted request.
- `fs_to_ds_valid`  out  1  IF holds a valid instruction.
- `fs_pc`  out  32  PC of the instruction in IF.
- `fs_inst`  out  32  instruction word in IF.

## Operation
- Registered state: `fs_valid`, `fs_pc_r`, `buf_valid`, `buf_inst`.
- IF ready_go is always 1. `fs_allowin = !fs_valid || ds_allowin`.
- nextpc priority:
  - `flush` → `flush_target`.
  - else `br_taken` → `br_target`.
  - else `fs_pc_r + 4`, with 32-bit wrap.
- Target alignment is not checked. Low bits pass through unchanged; address errors are handled downstream.
- `inst_sram_en = resetn && (flush || fs_allowin)`, and `inst_sram_addr = nextpc` always.
- On each clock edge where `inst_sram_en` is high: `fs_valid ← 1` and `fs_pc_r ← nextpc`.
- `br_taken` without `fs_allowin` has no effect. Decode holds `br_taken` until it can leave, and the redirect happens on the cycle the delay slot is accepted.
- Skid buffer:
  - First stall cycle (`fs_valid && !ds_allowin && !buf_valid`): `buf_inst ← inst_sram_rdata` and `buf_valid ← 1`.
  - Cleared when `ds_allowin` or `flush`.
  - `fs_inst = buf_valid ? buf_inst : inst_sram_rdata`.
- `fs_to_ds_valid = fs_valid && !flush`. `fs_inst` and `fs_pc` are forced to 0 when `!fs_valid`.
- `flush` discards the instruction in IF, ignores `ds_allowin` and `br_taken`, and clears `buf_valid`.

## Timing
- Reset, asynchronous and immediate:
  - `fs_valid=0`, `fs_pc_r=RESET_PC-4`, `buf_valid=0`, `buf_inst=0`.
  - Outputs while `resetn` is low: `inst_sram_en=0`, `inst_sram_addr=RESET_PC`, `fs_to_ds_valid=0`, `fs_pc=0`, `fs_inst=0`.
- Cycle 0 after `resetn` rises: `en=1`, `addr=RESET_PC`.
- Cycle 1: `fs_to_ds_valid=1`, `fs_pc=RESET_PC`, `fs_inst` equals the SRAM word.
- Fetch-to-offer latency is 1 cycle, with a throughput of 1 instruction/cycle while `ds_allowin` is high.
- Stalls of any length:
  - `fs_pc` and `fs_inst` stay stable.
  - No SRAM request is issued.
  - `inst_sram_rdata` may change freely after the first stall cycle.
- Redirect penalty: 0 bubbles for a branch (delay slot covers it), 1 cycle for a flush.
- Flush while stalled: the new request is issued the same cycle, and `fs_valid` stays 1 with the new PC.
- Flush in the first cycle after reset: the flush target wins over `RESET_PC`.
- Reset asserted mid-stall: the buffered instruction is lost, and `fs_to_ds_valid` drops in the same cycle.

## Structure
- Shared package `cpu_pkg`:
  - `RESET_PC_DEFAULT`, `XLEN=32`, `INST_NOP=32'h0`.
  - Typedef `fs_ds_bus_t = {pc[31:0], inst[31:0]}`, also used by decode.
- One sub-module `fetch_skid_buf`, which owns `buf_valid`/`buf_inst` and the output mux. Inputs: `capture`, `release`, `rdata`.
- nextpc mux and PC register live in `fetch_stage`.

## Test plan
- Reset release, `ds_allowin=1`, SRAM model returning the address as data → addresses `BFC00000`, `BFC00004`, …; `fs_inst` equals `fs_pc` each cycle from cycle 1.
- `ds_allowin=0` for 5 cycles at `fs_pc=BFC00008`, SRAM output scrambled after the first cycle → `fs_inst` holds `BFC00008`, `en=0` throughout, next issued address `BFC0000C`.
- `br_taken=1`, `br_target=BFC00100` while IF holds `BFC00010`, `ds_allowin=1` → next fetch `BFC00100`, with `BFC00010` (delay slot) delivered first.
- `br_taken=1` with `ds_allowin=0` for 3 cycles, then 1 → no request during the stall; the redirect to the target is issued on the release cycle.
- `flush=1`, `flush_target=BFC00380` during a stall with buffer full → `fs_to_ds_valid=0` that cycle, `addr=BFC00380`, buffer cleared, next `fs_pc=BFC00380`.
- `resetn` pulsed low mid-stream → outputs drop immediately; refetch starts at `BFC00000`.
